// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory port plus the decode-facing instruction stream.
// Signal prefixes describe direction as seen from the fetch unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] i_read_data;
  logic              i_redirect;
  logic [ADDR_W-1:0] i_redirect_target;
  logic              i_instr_ready;
  logic              o_instr_valid;
  logic [DATA_W-1:0] o_instr;
  logic [ADDR_W-1:0] o_instr_pc;

  modport master (
    output o_address,
    input  i_read_data,
    input  i_redirect,
    input  i_redirect_target,
    input  i_instr_ready,
    output o_instr_valid,
    output o_instr,
    output o_instr_pc
  );

  modport slave (
    input  o_address,
    output i_read_data,
    output i_redirect,
    output i_redirect_target,
    output i_instr_ready,
    input  o_instr_valid,
    input  o_instr,
    input  o_instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register feeding a small {instr, pc} FIFO toward decode.
// Redirect flushes the FIFO and reloads the PC; reset overrides everything.
module instr_fetch_unit #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  instr_fetch_unit_if.master io_bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_fifo_instr [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];

  logic w_valid;
  logic w_deq;
  logic w_fetch;

  assign w_valid = (r_count != '0);
  assign w_deq   = w_valid & io_bus.i_instr_ready;
  // A full buffer can still accept a fetch when the head leaves on the same edge.
  assign w_fetch = ~io_bus.i_redirect & ((r_count < FULL) | w_deq);

  assign io_bus.o_address     = r_pc;
  assign io_bus.o_instr_valid = w_valid;
  assign io_bus.o_instr       = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
  assign io_bus.o_instr_pc    = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (io_bus.i_redirect) begin
      r_pc     <= io_bus.i_redirect_target;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fetch) begin
        r_pc     <= r_pc + ADDR_W'(1);
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_fetch, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_fetch) begin
      r_fifo_instr[r_wr_ptr] <= io_bus.i_read_data;
      r_fifo_pc[r_wr_ptr]    <= r_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized + directed bench for instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DP = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  int   m_pc;
  int   m_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  // Instruction memory: IM[n] = n + 0x100
  assign bus.i_read_data = DW'(bus.o_address) + 32'h100;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Check current outputs against the model, drive one cycle of inputs, advance model and clock.
  task automatic step(input logic r, input logic rd, input int tgt, input logic rdy);
    bit nonempty;
    bit deq;
    bit fetch;
    nonempty = (m_q.size() > 0);
    chk("valid", 32'(bus.o_instr_valid), 32'(nonempty));
    chk("instr", bus.o_instr, nonempty ? 32'(m_q[0] + 'h100) : 32'h0);
    chk("ipc",   32'(bus.o_instr_pc), nonempty ? 32'(m_q[0]) : 32'h0);
    chk("addr",  32'(bus.o_address), 32'(m_pc));
    rst                   = r;
    bus.i_redirect        = rd;
    bus.i_redirect_target = AW'(tgt);
    bus.i_instr_ready     = rdy;
    if (r) begin
      m_q.delete();
      m_pc = 0;
    end else if (rd) begin
      m_q.delete();
      m_pc = tgt % (1 << AW);
    end else begin
      deq   = nonempty && rdy;
      fetch = (m_q.size() < DP) || deq;
      if (deq) void'(m_q.pop_front());
      if (fetch) begin
        m_q.push_back(m_pc);
        m_pc = (m_pc + 1) % (1 << AW);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_at(input int base);
    step(0, 1, base, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    rst                   = 1'b1;
    bus.i_redirect        = 1'b0;
    bus.i_redirect_target = '0;
    bus.i_instr_ready     = 1'b0;
    m_pc = 0;
    m_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.o_instr_valid), 32'h0);
    chk("rst_addr",  32'(bus.o_address), 32'h0);

    // streaming from reset
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // backpressure
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("bp_addr", 32'(bus.o_address), 32'd2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // flush with full FIFO holding PCs 4,5
    fill_at(4);
    chk("full_addr", 32'(bus.o_address), 32'd6);
    step(0, 1, 12, 1);
    chk("flush_valid", 32'(bus.o_instr_valid), 32'h0);
    chk("flush_addr",  32'(bus.o_address), 32'd12);
    step(0, 0, 0, 1);
    chk("flush_instr", bus.o_instr, 32'h10C);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // PC wrap
    step(0, 1, 63, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // back-to-back redirects
    step(0, 1, 20, 1);
    step(0, 1, 30, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // reset overrides redirect with full FIFO
    fill_at(40);
    step(1, 1, 9, 1);
    chk("rst_mid_addr", 32'(bus.o_address), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // full + simultaneous dequeue
    fill_at(50);
    step(0, 0, 0, 1);
    chk("fd_valid", 32'(bus.o_instr_valid), 32'h1);
    chk("fd_addr",  32'(bus.o_address), 32'd53);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic rd;
      logic rdy;
      r   = ($urandom_range(0, 99) < 2);
      rd  = ($urandom_range(0, 99) < 7);
      rdy = ($urandom_range(0, 99) < 65);
      step(r, rd, int'($urandom_range(0, (1 << AW) - 1)), rdy);
    end
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6: width of the instruction word address.
REQ-002 The block SHALL have parameter DATA_W, default 32: instruction width.
REQ-003 The block SHALL have parameter DEPTH, default 2: fetch buffer entries (power of two, >=2).
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Address  output  ADDR_W  word address presented to instruction memory; equals PC register.
REQ-007 ReadData  input  DATA_W  instruction memory data; combinational from Address, valid in the same cycle.
REQ-008 Redirect  input  1  branch/jump taken; one-cycle pulse.
REQ-009 RedirectTarget  input  ADDR_W  new PC, sampled when Redirect=1.
REQ-010 InstrReady  input  1  decode stage accepts the head instruction this cycle.
REQ-011 InstrValid  output  1  buffer head holds a valid instruction.
REQ-012 Instr  output  DATA_W  head instruction; 0 when InstrValid=0.
REQ-013 InstrPC  output  ADDR_W  word address of head instruction; 0 when InstrValid=0.

Function
REQ-014 State SHALL be: PC register, DEPTH-entry FIFO of {instruction, PC}, occupancy count 0..DEPTH.
REQ-015 Dequeue SHALL occur when InstrValid=1 and InstrReady=1; the head entry is removed at the edge.
REQ-016 Fetch SHALL occur when Redirect=0 and (count<DEPTH or dequeue); at the edge, {ReadData, PC} enqueues at tail and PC <= PC+1.
REQ-017 PC increment SHALL wrap modulo 2^ADDR_W (63 -> 0 at default); no error flag.
REQ-018 Full with no dequeue SHALL hold PC and FIFO unchanged; Address stays stable.
REQ-019 Full with simultaneous dequeue SHALL fetch and dequeue in the same edge; count unchanged.
REQ-020 Empty with fetch SHALL make InstrValid=1 the following cycle (one-cycle fetch latency); no combinational bypass of ReadData to Instr.
REQ-021 Redirect=1 SHALL have priority over fetch and dequeue: at the edge, FIFO flushed (count=0), PC <= RedirectTarget, no enqueue.
REQ-022 The cycle after Redirect, InstrValid SHALL be 0 and Address SHALL equal RedirectTarget; the first instruction at RedirectTarget appears one cycle later.
REQ-023 Back-to-back Redirect pulses SHALL each take effect; the last one determines PC.
REQ-024 Instructions SHALL leave the FIFO in fetch order with their originating PC; no entry is duplicated or dropped except by flush.
REQ-025 count SHALL never exceed DEPTH nor underflow; dequeue when empty is impossible since InstrValid=0.

Reset
REQ-026 Reset=1 at an edge SHALL set PC=0, count=0, FIFO pointers=0; InstrValid=0, Instr=0, InstrPC=0, Address=0 from the next cycle.
REQ-027 Reset SHALL override Redirect, fetch and dequeue in the same cycle, including mid-operation with a full FIFO.
REQ-028 First fetch from address 0 SHALL occur at the first edge with Reset=0.

Verification
REQ-029 Streaming: Reset released, InstrReady=1 held, memory model IM[n]=n+0x100 -> from cycle 1 InstrValid=1, Instr/InstrPC = 0x100/0, 0x101/1, 0x102/2 on consecutive cycles.
REQ-030 Backpressure: InstrReady=0 for cycles 1-4 -> count reaches 2 (PC 0,1), Address holds 2; InstrReady=1 -> PCs 0,1,2,3 delivered in order, none lost or repeated.
REQ-031 Flush: FIFO full (PC 4,5), Redirect=1, RedirectTarget=12, InstrReady=1 -> next cycle InstrValid=0, Address=12; following cycle Instr=0x10C, InstrPC=12; PCs 4,5 never delivered after the pulse.
REQ-032 Wrap: Redirect to 63 with InstrReady=1 -> delivered PCs 63, 0, 1 with Instr 0x13F, 0x100, 0x101.
REQ-033 Reset mid-operation: FIFO full, Reset=1 with Redirect=1 (target 9) and InstrReady=1 -> next cycle InstrValid=0, Address=0; after release first delivered InstrPC=0.
REQ-034 Simultaneous full+dequeue: count=2, InstrReady=1 for one cycle -> count stays 2, head advances by one, PC advances by one.
